// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: synchronised, edge/level-qualified, masked requests
// reported through PEND/MASK/CAUSE/MODE/SWI registers and a single registered o_int line.
module int_ctrl #(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [15:0]      i_addr,
  input  logic [15:0]      i_wdata,
  input  logic             i_we,
  output logic             o_hit,
  output logic [15:0]      o_rdata,
  input  logic [N_SRC-1:0] i_irq,
  output logic             o_int
);

  localparam logic [2:0] RegPend  = 3'd0;
  localparam logic [2:0] RegMask  = 3'd1;
  localparam logic [2:0] RegCause = 3'd2;
  localparam logic [2:0] RegMode  = 3'd3;
  localparam logic [2:0] RegSwi   = 3'd4;

  logic [15:0]      offset;
  logic [2:0]       reg_sel;
  logic             wr;
  logic [N_SRC-1:0] wdata_n;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] s_dly_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] w1c, swi;
  logic [N_SRC-1:0] masked;
  logic [3:0]       cause_idx;
  logic [15:0]      cause;
  logic [15:0]      rdata_d;

  // Modular subtraction keeps the decode a single compare on the upper offset bits.
  assign offset  = i_addr - BASE_ADDR;
  assign o_hit   = (offset[15:3] == 13'd0);
  assign reg_sel = offset[2:0];
  assign wr      = i_ce & i_we & o_hit;
  assign wdata_n = i_wdata[N_SRC-1:0];

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = s & ~s_dly_q;
  assign masked = pend_q & mask_q;

  always_comb begin
    w1c = '0;
    swi = '0;
    if (wr && reg_sel == RegPend) w1c = wdata_n;
    if (wr && reg_sel == RegSwi)  swi = wdata_n;
    // Edge sources: set beats clear. Level sources simply follow the synchronised input.
    pend_d = (mode_q & ((pend_q & ~w1c) | rise | swi)) | (~mode_q & s);
  end

  always_comb begin
    cause_idx = 4'd0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (masked[i]) cause_idx = i[3:0];
    end
    cause = {|masked, 11'd0, cause_idx};
  end

  always_comb begin
    rdata_d = '0;
    if (o_hit) begin
      case (reg_sel)
        RegPend:  rdata_d[N_SRC-1:0] = pend_q;
        RegMask:  rdata_d[N_SRC-1:0] = mask_q;
        RegCause: rdata_d            = cause;
        RegMode:  rdata_d[N_SRC-1:0] = mode_q;
        default:  rdata_d            = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      s_dly_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      o_rdata <= '0;
      o_int   <= 1'b0;
    end else if (i_ce) begin
      sync_q[0] <= i_irq;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      s_dly_q <= s;
      pend_q  <= pend_d;
      if (wr && reg_sel == RegMask) mask_q <= wdata_n;
      if (wr && reg_sel == RegMode) mode_q <= wdata_n;
      o_rdata <= rdata_d;
      o_int   <= |masked;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; inputs change on negedge, outputs sampled on negedge.
module tb_int_ctrl;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        we;
  logic        hit;
  logic [15:0] rdata;
  logic [7:0]  irq;
  logic        int_out;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctrl #(
    .BASE_ADDR  (BASE),
    .N_SRC      (8),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_ce   (ce),
    .i_addr (addr),
    .i_wdata(wdata),
    .i_we   (we),
    .o_hit  (hit),
    .o_rdata(rdata),
    .i_irq  (irq),
    .o_int  (int_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    addr = a;
    we   = 1'b0;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b0; ce = 1'b1; we = 1'b0; addr = 16'h0000; wdata = 16'h0000; irq = 8'h00;
    tick(3);
    n_checks++;
    if (int_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_int: got %b expected 0", int_out);
    end
    n_checks++;
    if (rdata !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0000", rdata);
    end
    rst = 1'b1;
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_pend: got %h expected 0000", d); end
    bus_read(BASE + 16'd1, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_mask: got %h expected 0000", d); end
    bus_read(BASE + 16'd3, d);
    n_checks++;
    if (d !== 16'h00FF) begin n_fail++; $display("FAIL reset_mode: got %h expected 00ff", d); end
    bus_read(BASE + 16'd2, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_cause: got %h expected 0000", d); end
  endtask

  task automatic test_edge_latency();
    logic [15:0] d;
    bus_write(BASE + 16'd1, 16'h0001);
    irq[0] = 1'b1;
    tick(1);
    irq[0] = 1'b0;
    tick(2);
    n_checks++;
    if (int_out !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b expected 0", int_out); end
    tick(1);
    n_checks++;
    if (int_out !== 1'b1) begin n_fail++; $display("FAIL lat_4clk: got %b expected 1", int_out); end
    bus_read(BASE + 16'd2, d);
    n_checks++;
    if (d !== 16'h8000) begin n_fail++; $display("FAIL cause_src0: got %h expected 8000", d); end
    bus_write(BASE + 16'd0, 16'h0001);
    n_checks++;
    if (int_out !== 1'b1) begin n_fail++; $display("FAIL w1c_hold: got %b expected 1", int_out); end
    tick(1);
    n_checks++;
    if (int_out !== 1'b0) begin n_fail++; $display("FAIL w1c_int: got %b expected 0", int_out); end
  endtask

  task automatic test_priority();
    logic [15:0] d;
    bus_write(BASE + 16'd1, 16'h00FF);
    irq = 8'h24;
    tick(5);
    bus_read(BASE + 16'd2, d);
    n_checks++;
    if (d !== 16'h8002) begin n_fail++; $display("FAIL cause_2_5: got %h expected 8002", d); end
    bus_write(BASE + 16'd0, 16'h0004);
    bus_read(BASE + 16'd2, d);
    n_checks++;
    if (d !== 16'h8005) begin n_fail++; $display("FAIL cause_5: got %h expected 8005", d); end
    bus_write(BASE + 16'd0, 16'h0020);
    bus_read(BASE + 16'd2, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL cause_none: got %h expected 0000", d); end
    n_checks++;
    if (int_out !== 1'b0) begin n_fail++; $display("FAIL prio_int: got %b expected 0", int_out); end
    irq = 8'h00;
    tick(4);
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL fall_no_pend: got %h expected 0000", d); end
  endtask

  task automatic test_level();
    logic [15:0] d;
    bus_write(BASE + 16'd3, 16'h00FE);
    bus_write(BASE + 16'd1, 16'h0001);
    irq[0] = 1'b1;
    tick(4);
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0001) begin n_fail++; $display("FAIL level_pend: got %h expected 0001", d); end
    bus_write(BASE + 16'd0, 16'h0001);
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0001) begin n_fail++; $display("FAIL level_w1c: got %h expected 0001", d); end
    irq[0] = 1'b0;
    tick(3);
    n_checks++;
    if (int_out !== 1'b1) begin n_fail++; $display("FAIL level_int_hold: got %b expected 1", int_out); end
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL level_drop: got %h expected 0000", d); end
    n_checks++;
    if (int_out !== 1'b0) begin n_fail++; $display("FAIL level_int_fall: got %b expected 0", int_out); end
    bus_write(BASE + 16'd3, 16'h00FF);
  endtask

  task automatic test_set_wins();
    logic [15:0] d;
    bus_write(BASE + 16'd1, 16'h0000);
    bus_write(BASE + 16'd4, 16'h0008);
    irq[3] = 1'b1;
    tick(2);
    // Rising edge is now visible to the pending logic; the W1C lands on the same clock.
    addr = BASE + 16'd0; wdata = 16'h0008; we = 1'b1;
    tick(1);
    we = 1'b0;
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0008) begin n_fail++; $display("FAIL set_wins: got %h expected 0008", d); end
    irq[3] = 1'b0;
    bus_write(BASE + 16'd4, 16'h0010);
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0018) begin n_fail++; $display("FAIL swi_pend: got %h expected 0018", d); end
    tick(3);
    n_checks++;
    if (int_out !== 1'b0) begin n_fail++; $display("FAIL swi_masked_int: got %b expected 0", int_out); end
    bus_read(BASE + 16'd4, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL swi_read: got %h expected 0000", d); end
  endtask

  task automatic test_decode();
    logic [15:0] d;
    bus_write(BASE + 16'd6, 16'hFFFF);
    bus_write(BASE - 16'd1, 16'hFFFF);
    bus_read(BASE + 16'd6, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL rsvd_read: got %h expected 0000", d); end
    n_checks++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_rsvd: got %b expected 1", hit); end
    bus_read(BASE - 16'd1, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL below_read: got %h expected 0000", d); end
    n_checks++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_below: got %b expected 0", hit); end
    addr = BASE + 16'd8;
    #1;
    n_checks++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_above: got %b expected 0", hit); end
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0018) begin n_fail++; $display("FAIL decode_pend: got %h expected 0018", d); end
    bus_read(BASE + 16'd1, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL decode_mask: got %h expected 0000", d); end
    bus_read(BASE + 16'd3, d);
    n_checks++;
    if (d !== 16'h00FF) begin n_fail++; $display("FAIL decode_mode: got %h expected 00ff", d); end
  endtask

  task automatic test_clock_enable();
    logic [15:0] d;
    bus_read(BASE + 16'd0, d);
    ce = 1'b0;
    addr = BASE + 16'd1; wdata = 16'h00FF; we = 1'b1;
    irq = 8'h02;
    tick(4);
    irq = 8'h00;
    we = 1'b0;
    tick(3);
    n_checks++;
    if (rdata !== 16'h0018) begin n_fail++; $display("FAIL ce_rdata_hold: got %h expected 0018", rdata); end
    n_checks++;
    if (int_out !== 1'b0) begin n_fail++; $display("FAIL ce_int: got %b expected 0", int_out); end
    ce = 1'b1;
    bus_read(BASE + 16'd1, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL ce_mask: got %h expected 0000", d); end
    tick(4);
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0018) begin n_fail++; $display("FAIL ce_pend: got %h expected 0018", d); end

    bus_write(BASE + 16'd1, 16'h0018);
    tick(1);
    n_checks++;
    if (int_out !== 1'b1) begin n_fail++; $display("FAIL pre_rst_int: got %b expected 1", int_out); end
    ce = 1'b0;
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (int_out !== 1'b0) begin n_fail++; $display("FAIL rst_ce_int: got %b expected 0", int_out); end
    n_checks++;
    if (rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_ce_rdata: got %h expected 0000", rdata); end
    rst = 1'b1;
    ce = 1'b1;
    bus_read(BASE + 16'd0, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_ce_pend: got %h expected 0000", d); end
    bus_read(BASE + 16'd1, d);
    n_checks++;
    if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_ce_mask: got %h expected 0000", d); end
    bus_read(BASE + 16'd3, d);
    n_checks++;
    if (d !== 16'h00FF) begin n_fail++; $display("FAIL rst_ce_mode: got %h expected 00ff", d); end
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_priority();
    test_level();
    test_set_wins();
    test_decode();
    test_clock_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
